operand_skew_feeder: RTL and testbench



---
 rtl/operand_skew_feeder_pkg.sv | 29 ++
 rtl/operand_skew_feeder_if.sv | 30 +++
 rtl/operand_skew_feeder_skew_lane.sv | 32 +++
 rtl/operand_skew_feeder.sv | 154 +++++++++++++++
 tb/tb_operand_skew_feeder.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/operand_skew_feeder_pkg.sv
// Shared types and sizing helpers for the systolic-array operand skew feeder.
// Holds the controller state encoding, drain-counter sizing and lane offsets.
package operand_skew_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    // Cycles spent in DRAIN after the last beat, so that the deepest diagonal
    // (lane N-1 plus N-1 hops through the array plus the MAC latency) completes.
    function automatic int drain_load(input int n, input int mac_lat);
        return 2 * n + mac_lat - 2;
    endfunction

    function automatic int drain_cnt_w(input int n, input int mac_lat);
        int v;
        v = drain_load(n, mac_lat);
        return (v < 1) ? 1 : $clog2(v + 1);
    endfunction

    // Bit offset of a lane inside a packed multi-lane bus.
    function automatic int lane_lo(input int lane, input int op_width);
        return lane * op_width;
    endfunction

endpackage

// File: rtl/operand_skew_feeder_if.sv
// Beat handshake between the operand source and the skew feeder:
// one A column plus the matching B row per accepted beat.
interface operand_skew_feeder_if #(
    parameter int N        = 16,
    parameter int OP_WIDTH = 8
);

    logic                  in_valid;
    logic                  in_ready;
    logic                  in_last;
    logic [N*OP_WIDTH-1:0] in_a_col;
    logic [N*OP_WIDTH-1:0] in_b_row;

    modport master (
        output in_valid,
        output in_last,
        output in_a_col,
        output in_b_row,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_last,
        input  in_a_col,
        input  in_b_row,
        output in_ready
    );

endinterface

// File: rtl/operand_skew_feeder_skew_lane.sv
// Depth-D, width-W shift chain that clears to zero; delays one operand lane
// by D cycles so lane i of the array sees its data i cycles after lane 0.
module operand_skew_feeder_skew_lane #(
    parameter int D = 1,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage_q [D];

    // NOTE: every stage is reset, not just the head, so a mid-operation reset
    // leaves the array inputs at zero immediately instead of flushing stale data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < D; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            stage_q[0] <= din;
            for (int k = 1; k < D; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign dout = stage_q[D-1];

endmodule

// File: rtl/operand_skew_feeder.sv
// Skews A columns / B rows into an N x N systolic MAC array, clears it, and
// flags completion. Optional macro FEEDER_BEAT_COUNT_EN adds a beat counter.
module operand_skew_feeder
    import operand_skew_feeder_pkg::*;
#(
    parameter int N        = 16,
    parameter int OP_WIDTH = 8,
    parameter int MAC_LAT  = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    operand_skew_feeder_if.slave  in_if,
    output logic [N*OP_WIDTH-1:0] new_a_column,
    output logic [N*OP_WIDTH-1:0] new_b_row,
    output logic                  array_clear,
    output logic                  busy,
    output logic                  done
`ifdef FEEDER_BEAT_COUNT_EN
    ,
    output logic [15:0]           beat_count
`endif
);

    localparam int                LOAD_VAL = drain_load(N, MAC_LAT);
    localparam int                CNT_W    = drain_cnt_w(N, MAC_LAT);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LOAD_VAL);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               ready;
    logic               accept;
    logic               last_accept;
    logic [N*OP_WIDTH-1:0] a_feed;
    logic [N*OP_WIDTH-1:0] b_feed;

    assign accept      = in_if.in_valid & ready;
    assign last_accept = accept & in_if.in_last;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (start)       state_d = CLEAR;
            CLEAR:                   state_d = STREAM;
            STREAM: if (last_accept) state_d = DRAIN;
            DRAIN:  if (cnt_q == '0) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_comb begin
        ready       = 1'b0;
        array_clear = 1'b0;
        busy        = (state_q != IDLE);
        unique case (state_q)
            CLEAR:   array_clear = 1'b1;
            STREAM:  ready       = 1'b1;
            default: ;
        endcase
    end

    assign in_if.in_ready = ready;

    // Drain countdown; done is registered so it lines up with the IDLE cycle.
    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (state_q == STREAM && last_accept) begin
            cnt_d = CNT_LOAD;
        end else if (state_q == DRAIN) begin
            if (cnt_q == '0) begin
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;

    // Cycles without a handshake feed zero beats so the diagonals stay aligned.
    assign a_feed = accept ? in_if.in_a_col : '0;
    assign b_feed = accept ? in_if.in_b_row : '0;

    for (genvar i = 0; i < N; i++) begin : g_lane
        operand_skew_feeder_skew_lane #(
            .D (i + 1),
            .W (OP_WIDTH)
        ) u_a_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (a_feed[lane_lo(i, OP_WIDTH) +: OP_WIDTH]),
            .dout    (new_a_column[lane_lo(i, OP_WIDTH) +: OP_WIDTH])
        );

        operand_skew_feeder_skew_lane #(
            .D (i + 1),
            .W (OP_WIDTH)
        ) u_b_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (b_feed[lane_lo(i, OP_WIDTH) +: OP_WIDTH]),
            .dout    (new_b_row[lane_lo(i, OP_WIDTH) +: OP_WIDTH])
        );
    end

`ifdef FEEDER_BEAT_COUNT_EN
    logic [15:0] beat_q, beat_d;

    always_comb begin
        beat_d = beat_q;
        if (state_q == CLEAR) begin
            beat_d = '0;
        end else if (accept && beat_q != 16'hFFFF) begin
            beat_d = beat_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end

    assign beat_count = beat_q;
`endif

endmodule

// File: tb/tb_operand_skew_feeder.sv
// Directed bench for operand_skew_feeder (N=4): drives beats, models the
// downstream systolic array, and checks skew, clear, done timing and results.
module tb_operand_skew_feeder;

    localparam int N       = 4;
    localparam int OW      = 8;
    localparam int MAC_LAT = 1;
    localparam int LW      = N * OW;
    localparam int DONE_LAT = 8;   // 2N edges after the last accept

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic          start   = 1'b0;
    logic [LW-1:0] new_a_column;
    logic [LW-1:0] new_b_row;
    logic          array_clear;
    logic          busy;
    logic          done;
`ifdef FEEDER_BEAT_COUNT_EN
    logic [15:0]   beat_count;
`endif

    operand_skew_feeder_if #(.N(N), .OP_WIDTH(OW)) bus ();

    operand_skew_feeder #(
        .N        (N),
        .OP_WIDTH (OW),
        .MAC_LAT  (MAC_LAT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .in_if        (bus),
        .new_a_column (new_a_column),
        .new_b_row    (new_b_row),
        .array_clear  (array_clear),
        .busy         (busy),
        .done         (done)
`ifdef FEEDER_BEAT_COUNT_EN
        ,
        .beat_count   (beat_count)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: samples at negedge, records edge numbers of events.
    int            first_a [N] = '{default: -1};
    int            first_b [N] = '{default: -1};
    int            beat_edge [8] = '{default: 0};
    int            beat_n     = 0;
    int            last_edge  = 0;
    int            done_cnt   = 0;
    int            clear_cnt  = 0;
    logic [LW-1:0] s_a = '0;
    logic [LW-1:0] s_b = '0;
    logic          s_clr = 1'b0;

    always @(negedge clk) begin
        s_a   = new_a_column;
        s_b   = new_b_row;
        s_clr = array_clear;
        if (array_clear) begin
            clear_cnt++;
            beat_n = 0;
            for (int i = 0; i < N; i++) begin
                first_a[i] = -1;
                first_b[i] = -1;
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            if (beat_n < 8) beat_edge[beat_n] = cyc + 1;
            beat_n++;
            if (bus.in_last) last_edge = cyc + 1;
        end
        for (int i = 0; i < N; i++) begin
            if (first_a[i] < 0 && new_a_column[i*OW +: OW] != '0) first_a[i] = cyc;
            if (first_b[i] < 0 && new_b_row[i*OW +: OW] != '0)    first_b[i] = cyc;
        end
        if (done) done_cnt++;
    end

    // Downstream output-stationary array: A moves right, B moves down,
    // C accumulates the product of the captured pair one cycle later.
    int a_q [N][N];
    int b_q [N][N];
    int c_m [N][N];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    a_q[i][j] <= 0;
                    b_q[i][j] <= 0;
                    c_m[i][j] <= 0;
                end
        end else begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin : pe
                    int av, bv;
                    av = (j == 0) ? int'(s_a[i*OW +: OW]) : a_q[i][(j == 0) ? 0 : j-1];
                    bv = (i == 0) ? int'(s_b[j*OW +: OW]) : b_q[(i == 0) ? 0 : i-1][j];
                    if (s_clr) begin
                        a_q[i][j] <= 0;
                        b_q[i][j] <= 0;
                        c_m[i][j] <= 0;
                    end else begin
                        a_q[i][j] <= av;
                        b_q[i][j] <= bv;
                        c_m[i][j] <= c_m[i][j] + a_q[i][j] * b_q[i][j];
                    end
                end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] ident_col(input int k);
        logic [LW-1:0] r;
        for (int i = 0; i < N; i++) r[i*OW +: OW] = (i == k) ? 8'd1 : 8'd0;
        return r;
    endfunction

    function automatic logic [LW-1:0] b_row(input int k);
        logic [LW-1:0] r;
        for (int j = 0; j < N; j++) r[j*OW +: OW] = OW'(4 * k + j + 1);
        return r;
    endfunction

    function automatic logic [LW-1:0] splat(input int v);
        logic [LW-1:0] r;
        for (int j = 0; j < N; j++) r[j*OW +: OW] = OW'(v);
        return r;
    endfunction

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
    endtask

    task automatic send(input logic [LW-1:0] a, input logic [LW-1:0] b,
                        input logic last, input string tag);
        logic ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a_col = a;
        bus.in_b_row = b;
        bus.in_last  = last;
        for (int t = 0; t < 20; t++) begin
            ok = bus.in_ready;
            step();
            if (ok) break;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_a_col = '0;
        bus.in_b_row = '0;
        check({tag, "_accepted"}, 64'(ok), 64'd1);
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int t = 0; t < 60; t++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        if (seen) check({tag, "_done_latency"}, 64'(cyc - last_edge), 64'(DONE_LAT));
    endtask

    task automatic check_c_is_b(input string tag);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                check($sformatf("%s_c%0d%0d", tag, i, j), 64'(c_m[i][j]), 64'(4 * i + j + 1));
    endtask

    task automatic check_skew(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_a_lane%0d_first", tag, i), 64'(first_a[i]), 64'(beat_edge[i] + i));
            check($sformatf("%s_b_lane%0d_first", tag, i), 64'(first_b[i]), 64'(beat_edge[0] + i));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base_clr;
        int base_done;

        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_a_col = '0;
        bus.in_b_row = '0;

        // Reset state
        #23 reset_n = 1'b1;
        step();
        check("rst_a",     64'(new_a_column), 64'd0);
        check("rst_b",     64'(new_b_row),    64'd0);
        check("rst_busy",  64'(busy),         64'd0);
        check("rst_done",  64'(done),         64'd0);
        check("rst_clear", 64'(array_clear),  64'd0);
        check("rst_ready", 64'(bus.in_ready), 64'd0);
`ifdef FEEDER_BEAT_COUNT_EN
        check("rst_beat_count", 64'(beat_count), 64'd0);
`endif

        // 1: identity A, back-to-back beats
        base_clr = clear_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        check("t1_clear_hi",  64'(array_clear),  64'd1);
        check("t1_clear_rdy", 64'(bus.in_ready), 64'd0);
        check("t1_busy",      64'(busy),         64'd1);
        step();
        check("t1_clear_lo",  64'(array_clear),  64'd0);
        check("t1_ready",     64'(bus.in_ready), 64'd1);
        for (int k = 0; k < N; k++) send(ident_col(k), b_row(k), k == N - 1, "t1_beat");
        check("t1_drain_rdy", 64'(bus.in_ready), 64'd0);
        wait_done("t1");
        check("t1_busy_at_done", 64'(busy), 64'd0);
        check_skew("t1");
        check_c_is_b("t1");
        check("t1_clear_count", 64'(clear_cnt - base_clr), 64'd1);
        step();
        check("t1_done_pulse", 64'(done), 64'd0);

        // 2: two bubbles between beats 1 and 2
        do_start();
        send(ident_col(0), b_row(0), 1'b0, "t2_beat");
        send(ident_col(1), b_row(1), 1'b0, "t2_beat");
        step();
        check("t2_bub1_b0", 64'(new_b_row[OW-1:0]),    64'd0);
        check("t2_bub1_a0", 64'(new_a_column[OW-1:0]), 64'd0);
        step();
        check("t2_bub2_b0", 64'(new_b_row[OW-1:0]),    64'd0);
        send(ident_col(2), b_row(2), 1'b0, "t2_beat");
        send(ident_col(3), b_row(3), 1'b1, "t2_beat");
        check("t2_gap", 64'(beat_edge[2] - beat_edge[1]), 64'd3);
        wait_done("t2");
        check_skew("t2");
        check_c_is_b("t2");
        step();

        // 3: K = 1
        do_start();
        send(splat(3), splat(5), 1'b1, "t3_beat");
        wait_done("t3");
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                check($sformatf("t3_c%0d%0d", i, j), 64'(c_m[i][j]), 64'd15);
        step();

        // 4: asynchronous reset mid-STREAM
        do_start();
        send(ident_col(0), b_row(0), 1'b0, "t4_beat");
        send(ident_col(1), b_row(1), 1'b0, "t4_beat");
        base_done = done_cnt;
        #2 reset_n = 1'b0;
        #1;
        check("t4_rst_a",     64'(new_a_column), 64'd0);
        check("t4_rst_b",     64'(new_b_row),    64'd0);
        check("t4_rst_busy",  64'(busy),         64'd0);
        check("t4_rst_ready", 64'(bus.in_ready), 64'd0);
        #3 reset_n = 1'b1;
        repeat (20) step();
        check("t4_no_done", 64'(done_cnt - base_done), 64'd0);
        do_start();
        send(splat(2), splat(7), 1'b1, "t4_beat");
        wait_done("t4");
        check("t4_c00", 64'(c_m[0][0]), 64'd14);
        check("t4_c33", 64'(c_m[N-1][N-1]), 64'd14);
        step();

        // 5: start ignored while busy; accepted alongside done
        base_clr = clear_cnt;
        do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        check("t5_stream_kept", 64'(bus.in_ready), 64'd1);
        check("t5_one_clear",   64'(clear_cnt - base_clr), 64'd1);
        for (int k = 0; k < N; k++) send(ident_col(k), b_row(k), k == N - 1, "t5_beat");
        start = 1'b1;
        step();
        start = 1'b0;
        check("t5_drain_busy",  64'(busy),         64'd1);
        check("t5_drain_clear", 64'(array_clear),  64'd0);
        check("t5_drain_rdy",   64'(bus.in_ready), 64'd0);
        wait_done("t5");
        check_c_is_b("t5");
        start = 1'b1;
        step();
        start = 1'b0;
        check("t5_restart_clear", 64'(array_clear), 64'd1);
        step();
        check("t5_restart_ready", 64'(bus.in_ready), 64'd1);
        send(splat(1), splat(1), 1'b1, "t5_beat");
        wait_done("t5b");
        check("t5_clear_count", 64'(clear_cnt - base_clr), 64'd2);
        step();

`ifdef FEEDER_BEAT_COUNT_EN
        // 6: beat counter, 5 beats with 3 bubbles
        do_start();
        send(ident_col(0), b_row(0), 1'b0, "t6_beat");
        step();
        send(ident_col(1), b_row(1), 1'b0, "t6_beat");
        step();
        send(ident_col(2), b_row(2), 1'b0, "t6_beat");
        step();
        send(ident_col(3), b_row(3), 1'b0, "t6_beat");
        send(splat(0), splat(0), 1'b1, "t6_beat");
        wait_done("t6");
        check("t6_beat_count", 64'(beat_count), 64'd5);
        step();
        check("t6_beat_hold", 64'(beat_count), 64'd5);
        do_start();
        check("t6_beat_cleared", 64'(beat_count), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
